serial_tx7: RTL and testbench
=============================

# serial_tx7

Serial frame transmitter for 7-bit words, sitting directly upstream of the 7-bit serial frame receiver. It accepts a parallel word through a valid/ready handshake and drives a single idle-high serial line. Each frame is one low start bit, seven data bits LSB first, optionally one parity bit, and one high stop bit. The bit period is a programmable number of `clk` cycles; the default of one bit per clock matches the receiver's one-bit-per-cycle sampling.

## Interface
- `CLKS_PER_BIT`, default 1: `clk` cycles per serial bit; legal range 1..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `ctrl`  in  1  reset, synchronous and active-low; sampled on rising `clk`.
- `tx_data`  in  7  word to send; captured on the accept edge.
- `tx_valid`  in  1  upstream asserts that `tx_data` is valid.
- `tx_ready`  out  1  high only in IDLE; accept occurs when `tx_valid && tx_ready` at a rising edge.
- `serial_out`  out  1  serial line, registered; idle level 1.
- `busy`  out  1  registered; 1 from the cycle after accept through the last stop-bit cycle.

## Operation
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE
  - `serial_out`=1, `tx_ready`=1, `busy`=0.
  - On accept: latch `tx_data` into a 7-bit shift register, clear the bit-period counter, go to START.
- START: `serial_out`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA
  - `serial_out`=shreg[0] for `CLKS_PER_BIT` cycles, then shift right and increment the 3-bit index.
  - After index 6 completes: go to PARITY if the macro is enabled, otherwise to STOP.
- PARITY: `serial_out`=even parity (XOR of the 7 latched bits) for `CLKS_PER_BIT` cycles, then go to STOP.
- STOP: `serial_out`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- Bit-period counter
  - 8 bits wide; counts 0..`CLKS_PER_BIT`-1.
  - The state/bit advances when the counter equals `CLKS_PER_BIT`-1, and the counter wraps to 0.
- While not in IDLE, `tx_valid` is ignored and `tx_data` changes have no effect; the latched word is used.
- Reset (`ctrl`=0 at an edge) in any state:
  - Next cycle: IDLE, `serial_out`=1, `busy`=0, `tx_ready`=1; the shift register and counters are cleared.
  - A frame in progress is aborted with no stop bit; the line simply returns high.
- Reset values: `serial_out`=1, `busy`=0, `tx_ready`=1.

## Timing
- Accept at edge k: `serial_out` goes 0 and `busy` goes 1 after edge k (visible in cycle k+1).
- Frame length: (9 + parity) × `CLKS_PER_BIT` cycles, from the first start cycle to the last stop cycle.
- After the last stop cycle the block spends at least one IDLE cycle before the next start bit.
  - Back-to-back frames with `tx_valid` held high: the line is high for `CLKS_PER_BIT`+1 cycles between frames.
- `tx_ready` is a combinational decode of state == IDLE; there is no path from `tx_valid` to `tx_ready`.

## Configuration
- `SERIAL_TX7_PARITY_EN` defined:
  - The PARITY state is compiled in.
  - Frame = start, 7 data, even parity, stop (10 bits).
- Not defined:
  - The state and parity logic are absent.
  - Frame = start, 7 data, stop (9 bits); this is the frame the existing receiver expects.

## Structure
- Shared package `serial7_pkg`:
  - State encoding constants IDLE, START, DATA, PARITY, STOP.
  - `DATA_W`=7.
  - A function computing even parity over `DATA_W` bits.
- One natural sub-module, `bit_timer`:
  - Inputs: `clk`, `ctrl`, a clear input.
  - Output: a `tick` pulse generated from `CLKS_PER_BIT`.
  - The FSM advances only on `tick`.

## Test plan
- Reset: hold `ctrl`=0 for 3 cycles, release -> `serial_out`=1, `busy`=0, `tx_ready`=1; line stays 1 with `tx_valid`=0.
- `CLKS_PER_BIT`=1, send 7'h55 -> `serial_out` sequence 0,1,0,1,0,1,0,1,1, then 1; `busy` high for exactly 9 cycles.
- `CLKS_PER_BIT`=4, send 7'h01 -> start low for 4 cycles; d0 high for 4 cycles; d1..d6 low for 24 cycles; stop high for 4 cycles.
- `tx_valid` held high with 7'h7F then 7'h00, `CLKS_PER_BIT`=1 -> two frames separated by 2 high cycles; during frame 1 `tx_data` changes to 7'h00 but frame 1 still carries 7'h7F.
- Reset mid-frame: `ctrl`=0 in the 4th data bit -> next cycle `serial_out`=1 and IDLE; a new accept of 7'h2A then yields a clean, complete frame.
- With `SERIAL_TX7_PARITY_EN`, send 7'h07 -> parity bit 1, frame of 10 bits; send 7'h03 -> parity bit 0.

Source files
------------

// File: rtl/serial7_pkg.sv
// Shared types and helpers for the 7-bit serial frame transmitter.
package serial7_pkg;

    localparam int DATA_W = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/serial_tx7_bit_timer.sv
// Bit-period timer: counts clk cycles within one serial bit and pulses tick
// on the last cycle of each bit period.
module bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic ctrl,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] TC = 8'(CLKS_PER_BIT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!ctrl) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tick = (cnt == TC);

endmodule

// File: rtl/serial_tx7.sv
// Serial transmitter for 7-bit words: start, 7 data LSB first, stop.
// Define SERIAL_TX7_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx7
    import serial7_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              ctrl,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serial_out,
    output logic              busy
);

    state_t            state, state_next;
    logic [DATA_W-1:0] shreg, shreg_next;
    logic [2:0]        idx, idx_next;
    logic              tick;
    logic              out_next;

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk   (clk),
        .ctrl  (ctrl),
        .clear (state == IDLE),
        .tick  (tick)
    );

`ifdef SERIAL_TX7_PARITY_EN
    logic par;

    always_ff @(posedge clk) begin
        if (!ctrl) begin
            par <= 1'b0;
        end else if (state == IDLE && tx_valid) begin
            par <= even_parity(tx_data);
        end
    end
`endif

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    shreg_next = tx_data;
                    idx_next   = 3'd0;
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    idx_next   = 3'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_next = {1'b0, shreg[DATA_W-1:1]};
                    if (idx == 3'd6) begin
                        idx_next = 3'd0;
`ifdef SERIAL_TX7_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end
            end
`ifdef SERIAL_TX7_PARITY_EN
            PARITY: begin
                if (tick) state_next = STOP;
            end
`endif
            STOP: begin
                if (tick) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level is decoded from the next state so the output register
    // presents the new bit in the same cycle the state changes.
    always_comb begin
        out_next = 1'b1;
        case (state_next)
            START:  out_next = 1'b0;
            DATA:   out_next = shreg_next[0];
`ifdef SERIAL_TX7_PARITY_EN
            PARITY: out_next = par;
`endif
            default: out_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!ctrl) begin
            state      <= IDLE;
            shreg      <= '0;
            idx        <= 3'd0;
            serial_out <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            idx        <= idx_next;
            serial_out <= out_next;
            busy       <= (state_next != IDLE);
        end
    end

    assign tx_ready = (state == IDLE);

endmodule

// File: tb/tb_serial_tx7.sv
// Directed bench for serial_tx7 at one and four clocks per bit.
module tb_serial_tx7;

    logic       clk = 1'b0;
    logic       ctrl = 1'b0;
    logic [6:0] tx_data = 7'h00;
    logic       v1 = 1'b0, v4 = 1'b0;
    logic       rdy1, so1, busy1;
    logic       rdy4, so4, busy4;

    int vectors = 0;
    int miscompares = 0;

`ifdef SERIAL_TX7_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif

    always #5 clk = ~clk;

    serial_tx7 #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .ctrl(ctrl), .tx_data(tx_data), .tx_valid(v1),
        .tx_ready(rdy1), .serial_out(so1), .busy(busy1)
    );

    serial_tx7 #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .ctrl(ctrl), .tx_data(tx_data), .tx_valid(v4),
        .tx_ready(rdy4), .serial_out(so4), .busy(busy4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [6:0] w, input int i);
        if (i == 0) return 1'b0;
        if (i <= 7) return w[i-1];
`ifdef SERIAL_TX7_PARITY_EN
        if (i == 8) return ^w;
`endif
        return 1'b1;
    endfunction

    function automatic logic pick(input int cpb, input logic a1, input logic a4);
        return (cpb == 1) ? a1 : a4;
    endfunction

    // Send one word on the selected instance and check every line cycle.
    task automatic run_frame(input int cpb, input logic [6:0] w, input string tag);
        tx_data = w;
        if (cpb == 1) v1 = 1'b1; else v4 = 1'b1;
        check({tag, "_ready_pre"}, pick(cpb, rdy1, rdy4), 1'b1);
        step();
        v1 = 1'b0;
        v4 = 1'b0;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < cpb; c++) begin
                check($sformatf("%s_bit%0d_c%0d", tag, b, c), pick(cpb, so1, so4), frame_bit(w, b));
                check($sformatf("%s_busy%0d_c%0d", tag, b, c), pick(cpb, busy1, busy4), 1'b1);
                step();
            end
        end
        check({tag, "_idle_line"}, pick(cpb, so1, so4), 1'b1);
        check({tag, "_idle_busy"}, pick(cpb, busy1, busy4), 1'b0);
        check({tag, "_idle_ready"}, pick(cpb, rdy1, rdy4), 1'b1);
    endtask

    initial begin
        // Reset held for three cycles.
        ctrl = 1'b0;
        step(); step(); step();
        ctrl = 1'b1;
        check("rst_line1", so1, 1'b1);
        check("rst_busy1", busy1, 1'b0);
        check("rst_ready1", rdy1, 1'b1);
        check("rst_line4", so4, 1'b1);
        check("rst_busy4", busy4, 1'b0);
        check("rst_ready4", rdy4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_line1", so1, 1'b1);
            check("idle_line4", so4, 1'b1);
        end

        run_frame(1, 7'h55, "f55");
        run_frame(4, 7'h01, "f01_cpb4");

        // Back-to-back with valid held; data changes during frame 1.
        tx_data = 7'h7F;
        v1 = 1'b1;
        step();
        tx_data = 7'h00;
        for (int b = 0; b < NB; b++) begin
            check($sformatf("b2b1_bit%0d", b), so1, frame_bit(7'h7F, b));
            check($sformatf("b2b1_ready%0d", b), rdy1, 1'b0);
            step();
        end
        check("b2b_gap_line", so1, 1'b1);
        check("b2b_gap_ready", rdy1, 1'b1);
        check("b2b_gap_busy", busy1, 1'b0);
        step();
        v1 = 1'b0;
        for (int b = 0; b < NB; b++) begin
            check($sformatf("b2b2_bit%0d", b), so1, frame_bit(7'h00, b));
            check($sformatf("b2b2_busy%0d", b), busy1, 1'b1);
            step();
        end
        check("b2b_end_line", so1, 1'b1);
        check("b2b_end_busy", busy1, 1'b0);

        // Reset during the fourth data bit.
        step();
        tx_data = 7'h55;
        v1 = 1'b1;
        step();
        v1 = 1'b0;
        check("abort_start", so1, 1'b0);
        for (int b = 0; b < 4; b++) begin
            step();
            check($sformatf("abort_d%0d", b), so1, b[0] ? 1'b0 : 1'b1);
        end
        ctrl = 1'b0;
        step();
        ctrl = 1'b1;
        check("abort_line", so1, 1'b1);
        check("abort_busy", busy1, 1'b0);
        check("abort_ready", rdy1, 1'b1);
        step();
        check("abort_line_hold", so1, 1'b1);
        run_frame(1, 7'h2A, "f2A");

        // Parity cases (odd and even popcount).
        run_frame(1, 7'h07, "f07");
        run_frame(1, 7'h03, "f03");
        run_frame(4, 7'h07, "f07_cpb4");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
